// File: rtl/conv_window_mac.sv
// conv_window_mac
//   Multiply-accumulate stage for one convolution window. A window request
//   (top-left image address, destination address, last flag) is accepted in
//   IDLE. The block then issues KER_SIZE*KER_SIZE reads to the image RAM and
//   kernel RAM, accumulates the products, and writes one clipped pixel to the
//   filtered-image RAM.
//
//   Optional feature macro: CONV_ABS_EN
//     defined   : output is |acc >>> SHIFT| clipped to 2^PIX_W-1
//     undefined : negative results clip to 0
//
// Ports
//   clk         clock, all state on rising edge
//   rst         asynchronous active-low reset
//   win_valid   window request valid
//   win_ready   block can accept a window (IDLE only)
//   win_base    image address of the window's top-left pixel
//   win_dst     filtered-image address for the result
//   win_last    final window of the frame
//   im_rd_addr  image RAM read address (data returns next cycle)
//   im_rd_data  image RAM read data (unsigned)
//   k_rd_addr   kernel RAM read address (data returns next cycle)
//   k_rd_data   kernel RAM read data (two's-complement)
//   wr_en       filtered-image write strobe, one cycle per window
//   wr_addr     filtered-image write address
//   wr_data     filtered pixel
//   busy        high outside IDLE
//   done        frame complete, held until the next accepted window
module conv_window_mac #(
  parameter int IMG_SIZE = 10,
  parameter int KER_SIZE = 3,
  parameter int PIX_W    = 8,
  parameter int COEF_W   = 8,
  parameter int ACC_W    = 20,
  parameter int SHIFT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              win_valid,
  output logic              win_ready,
  input  logic [15:0]       win_base,
  input  logic [15:0]       win_dst,
  input  logic              win_last,
  output logic [15:0]       im_rd_addr,
  input  logic [PIX_W-1:0]  im_rd_data,
  output logic [15:0]       k_rd_addr,
  input  logic [COEF_W-1:0] k_rd_data,
  output logic              wr_en,
  output logic [15:0]       wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              done
);

  localparam int CW = (KER_SIZE > 1) ? $clog2(KER_SIZE) : 1;
  localparam int PW = PIX_W + COEF_W + 1;
  localparam logic [CW-1:0] KLAST = CW'(KER_SIZE - 1);
  localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W + 1)'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;

  state_t                   state_reg, state_next;
  logic [CW-1:0]            row_reg, row_next;
  logic [CW-1:0]            col_reg, col_next;
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  logic [15:0]              base_reg, dst_reg;
  logic                     last_reg;
  logic                     done_reg, done_next;
  logic                     accept;
  logic                     first_tap;

  // Product of unsigned pixel and signed coefficient, both widened to the
  // full product width so the multiply is exact.
  logic signed [PW-1:0]     pix_ext, coef_ext, product;
  logic signed [ACC_W-1:0]  acc_term;
  logic [15:0]              row_off;

  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W:0]    sh_ext, mag;
  logic [PIX_W-1:0]         clip_val;

  assign pix_ext  = $signed({{(PW-PIX_W){1'b0}}, im_rd_data});
  assign coef_ext = $signed({{(PW-COEF_W){k_rd_data[COEF_W-1]}}, k_rd_data});
  assign product  = pix_ext * coef_ext;
  assign acc_term = {{(ACC_W-PW){product[PW-1]}}, product};

  // The first FETCH cycle has no read data in flight yet; every later FETCH
  // cycle and the DRAIN cycle absorb the previous cycle's tap.
  assign first_tap = (row_reg == '0) && (col_reg == '0);

  assign row_off    = 16'(row_reg) * 16'(IMG_SIZE);
  assign im_rd_addr = (state_reg == FETCH) ? (base_reg + row_off + 16'(col_reg)) : '0;
  assign k_rd_addr  = (state_reg == FETCH) ? (16'(row_reg) * 16'(KER_SIZE) + 16'(col_reg)) : '0;

  assign win_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign wr_en     = (state_reg == WRITE);
  assign wr_addr   = (state_reg == WRITE) ? dst_reg : '0;
  assign wr_data   = (state_reg == WRITE) ? clip_val : '0;

  // Output scaling and clipping; one extra bit keeps |most negative| exact.
  assign shifted = acc_reg >>> SHIFT;
  assign sh_ext  = {shifted[ACC_W-1], shifted};

  always_comb begin
    clip_val = '0;
    mag      = sh_ext;
`ifdef CONV_ABS_EN
    if (sh_ext[ACC_W]) mag = -sh_ext;
`endif
    if (mag[ACC_W])         clip_val = '0;
    else if (mag > PIX_MAX) clip_val = '1;
    else                    clip_val = mag[PIX_W-1:0];
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    acc_next   = acc_reg;
    done_next  = done_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_valid) begin
          accept     = 1'b1;
          acc_next   = '0;
          row_next   = '0;
          col_next   = '0;
          done_next  = 1'b0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (!first_tap) acc_next = acc_reg + acc_term;
        if (col_reg == KLAST) begin
          col_next = '0;
          row_next = row_reg + CW'(1);
          if (row_reg == KLAST) state_next = DRAIN;
        end else begin
          col_next = col_reg + CW'(1);
        end
      end
      DRAIN: begin
        acc_next   = acc_reg + acc_term;
        state_next = WRITE;
      end
      WRITE: begin
        if (last_reg) done_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      acc_reg   <= '0;
      base_reg  <= '0;
      dst_reg   <= '0;
      last_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      acc_reg   <= acc_next;
      done_reg  <= done_next;
      if (accept) begin
        base_reg <= win_base;
        dst_reg  <= win_dst;
        last_reg <= win_last;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
module tb_conv_window_mac;

  localparam int IMG = 10;
  localparam int K   = 3;
  localparam int KK  = K * K;
  localparam int AW  = 20;
  localparam int SH  = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        win_valid = 1'b0;
  logic        win_ready;
  logic [15:0] win_base = '0;
  logic [15:0] win_dst = '0;
  logic        win_last = 1'b0;
  logic [15:0] im_rd_addr;
  logic [7:0]  im_rd_data = '0;
  logic [15:0] k_rd_addr;
  logic [7:0]  k_rd_data = '0;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_window_mac #(
    .IMG_SIZE(IMG), .KER_SIZE(K), .PIX_W(8), .COEF_W(8), .ACC_W(AW), .SHIFT(SH)
  ) dut (
    .clk(clk), .rst(rst),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_base(win_base), .win_dst(win_dst), .win_last(win_last),
    .im_rd_addr(im_rd_addr), .im_rd_data(im_rd_data),
    .k_rd_addr(k_rd_addr), .k_rd_data(k_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  // Synchronous-read RAM models
  logic [7:0] img_mem [0:1023];
  logic [7:0] ker_mem [0:15];

  always @(posedge clk) begin
    im_rd_data <= img_mem[im_rd_addr[9:0]];
    k_rd_data  <= ker_mem[k_rd_addr[3:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: sum of pixel*coef over the window, wrapped to ACC_W, shifted, clipped.
  function automatic logic [31:0] model_pix(input logic [15:0] b);
    longint s;
    longint v;
    logic [15:0] a;
    logic [AW-1:0] w;
    s = 0;
    for (int t = 0; t < KK; t++) begin
      a = b + 16'((t / K) * IMG + (t % K));
      s += longint'(img_mem[a[9:0]]) * longint'($signed(ker_mem[t]));
    end
    w = s[AW-1:0];
    v = longint'($signed(w)) >>> SH;
`ifdef CONV_ABS_EN
    if (v < 0) v = -v;
`endif
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 32'(v);
  endfunction

  // Behavioural model state: one active window measured in cycles since handshake
  int          cyc = 0;
  int          hs_cyc = 0;
  int          d_cur;
  bit          m_active = 0;
  bit          m_done = 0;
  logic [15:0] m_base, m_dst;
  bit          m_last;
  logic [31:0] m_pix;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0;
      m_done   = 0;
    end else begin
      d_cur = cyc - hs_cyc;
      if (m_active && d_cur == KK + 2 && m_last) m_done = 1;
      if (win_valid && (!m_active || d_cur >= KK + 3)) begin
        m_active = 1;
        m_base   = win_base;
        m_dst    = win_dst;
        m_last   = win_last;
        m_pix    = model_pix(win_base);
        m_done   = 0;
        hs_cyc   = cyc;
      end
      cyc++;
    end
  end

  // Compare process: every cycle, away from the active edge
  int d_cmp;
  int wr_log[$];
  logic [15:0] exp_im, exp_k;
  bit exp_ready, exp_wr;

  always @(negedge clk) begin
    if (rst) begin
      d_cmp     = cyc - hs_cyc;
      exp_ready = !m_active || d_cmp >= KK + 3;
      exp_wr    = m_active && d_cmp == KK + 2;
      exp_im    = '0;
      exp_k     = '0;
      if (m_active && d_cmp >= 1 && d_cmp <= KK) begin
        exp_im = m_base + 16'(((d_cmp - 1) / K) * IMG + ((d_cmp - 1) % K));
        exp_k  = 16'(d_cmp - 1);
      end
      chk("win_ready", 32'(win_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(!exp_ready));
      chk("im_rd_addr", 32'(im_rd_addr), 32'(exp_im));
      chk("k_rd_addr", 32'(k_rd_addr), 32'(exp_k));
      chk("wr_en", 32'(wr_en), 32'(exp_wr));
      chk("done", 32'(done), 32'(m_done));
      if (exp_wr) begin
        chk("wr_addr", 32'(wr_addr), 32'(m_dst));
        chk("wr_data", 32'(wr_data), m_pix);
      end
      if (wr_en) wr_log.push_back(cyc);
    end
  end

  task automatic send(input logic [15:0] b, input logic [15:0] dd, input logic l, input bit hold);
    int n;
    win_valid = 1'b1;
    win_base  = b;
    win_dst   = dd;
    win_last  = l;
    n = 0;
    while (!win_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!win_ready) begin
      chk("handshake_timeout", 32'(win_ready), 32'd1);
      win_valid = 1'b0;
    end else begin
      @(negedge clk);
      if (!hold) win_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!win_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(win_ready), 32'd1);
    @(negedge clk);
  endtask

  // Directed window: send returns in cycle 1; checks cycles 11 and 12.
  task automatic directed(input logic [15:0] b, input logic [15:0] dd, input logic [7:0] expd, input string nm);
    send(b, dd, 1'b0, 1'b0);
    repeat (KK + 1) @(negedge clk);
    chk({nm, "_wr_en"}, 32'(wr_en), 32'd1);
    chk({nm, "_wr_addr"}, 32'(wr_addr), 32'(dd));
    chk({nm, "_wr_data"}, 32'(wr_data), 32'(expd));
    @(negedge clk);
    chk({nm, "_ready12"}, 32'(win_ready), 32'd1);
  endtask

  logic [15:0] addr_exp [9] = '{16'd23, 16'd24, 16'd25, 16'd33, 16'd34, 16'd35, 16'd43, 16'd44, 16'd45};

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) img_mem[i] = 8'(i);
    for (int i = 0; i < 16; i++) ker_mem[i] = 8'd0;
    ker_mem[4] = 8'd1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_win_ready", 32'(win_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Address sequence, base 23, identity kernel -> pixel 34
    send(16'd23, 16'd5, 1'b0, 1'b0);
    for (int t = 0; t < KK; t++) begin
      chk("seq_im_addr", 32'(im_rd_addr), 32'(addr_exp[t]));
      chk("seq_k_addr", 32'(k_rd_addr), 32'(t));
      @(negedge clk);
    end
    chk("seq_im_addr_c10", 32'(im_rd_addr), 32'd0);
    chk("seq_k_addr_c10", 32'(k_rd_addr), 32'd0);
    @(negedge clk);
    chk("seq_wr_data", 32'(wr_data), 32'd34);
    wait_idle();

    // Identity kernel, image[i]=i, base 0, dst 7
    directed(16'd0, 16'd7, 8'd11, "ident");
    wait_idle();

    // Clipping high: all coefs 1, pixels 200 -> 1800
    for (int i = 0; i < 16; i++) ker_mem[i] = 8'd1;
    for (int i = 0; i < 1024; i++) img_mem[i] = 8'd200;
    directed(16'd0, 16'd9, (SH == 0) ? 8'd255 : 8'd225, "cliphi");
    wait_idle();

    // Negative sum: coefs -1, pixels 10 -> -90
    for (int i = 0; i < 16; i++) ker_mem[i] = 8'hFF;
    for (int i = 0; i < 1024; i++) img_mem[i] = 8'd10;
`ifdef CONV_ABS_EN
    directed(16'd12, 16'd3, 8'd90, "neg");
`else
    directed(16'd12, 16'd3, 8'd0, "neg");
`endif
    wait_idle();

    // Reset in FETCH cycle 5 aborts the window
    send(16'd0, 16'd2, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_im_addr", 32'(im_rd_addr), 32'd0);
    chk("abort_k_addr", 32'(k_rd_addr), 32'd0);
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(win_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wr_log.delete();
    repeat (15) @(negedge clk);
    chk("abort_no_write", 32'(wr_log.size()), 32'd0);

    // Randomized windows over three coefficient ranges
    for (int bt = 0; bt < 3; bt++) begin
      for (int i = 0; i < 1024; i++) img_mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 16; i++) begin
        case (bt)
          0: ker_mem[i] = 8'($urandom_range(0, 255));
          1: ker_mem[i] = 8'($signed($urandom_range(0, 6)) - 3);
          default: ker_mem[i] = 8'($urandom_range(0, 2));
        endcase
      end
      for (int w = 0; w < 10; w++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(16'($urandom_range(0, 7) * IMG + $urandom_range(0, 7)),
             16'($urandom_range(0, 65535)), 1'($urandom_range(0, 3) == 0), 1'b0);
      end
      wait_idle();
    end

    // Frame run: 64 windows back-to-back with valid held high
    for (int i = 0; i < 1024; i++) img_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) ker_mem[i] = 8'($signed($urandom_range(0, 8)) - 4);
    wr_log.delete();
    for (int i = 0; i < 64; i++)
      send(16'((i / 8) * IMG + (i % 8)), 16'(i), (i == 63), (i != 63));
    repeat (KK + 1) @(negedge clk);
    chk("frame_last_wr_en", 32'(wr_en), 32'd1);
    @(negedge clk);
    chk("frame_done", 32'(done), 32'd1);
    chk("frame_busy", 32'(busy), 32'd0);
    chk("frame_pulses", 32'(wr_log.size()), 32'd64);
    for (int i = 1; i < wr_log.size(); i++)
      chk("frame_spacing", 32'(wr_log[i] - wr_log[i-1]), 32'd12);
    repeat (3) @(negedge clk);
    chk("frame_done_hold", 32'(done), 32'd1);
    send(16'd0, 16'd1, 1'b0, 1'b0);
    chk("frame_done_clear", 32'(done), 32'd0);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_mac.md
Name: conv_window_mac

Overview:
- Datapath stage directly downstream of the convolution address controller.
- Accepts one window request per handshake: top-left image address, destination address and last flag.
- Sequences KER_SIZE×KER_SIZE reads from the image RAM and kernel RAM and multiply-accumulates them.
- Writes one clipped pixel to the filtered-image RAM per window.

Parameters:
IMG_SIZE, 10, image row length in pixels (row stride in image RAM)
KER_SIZE, 3, kernel side length; window = KER_SIZE² taps
PIX_W, 8, pixel width, unsigned
COEF_W, 8, kernel coefficient width, two's-complement signed
ACC_W, 20, accumulator width, signed
SHIFT, 0, arithmetic right shift applied to the final sum before clipping

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
win_valid  in  1  window request valid
win_ready  out  1  block can accept a window (high only in IDLE)
win_base  in  16  image address of window top-left pixel
win_dst  in  16  filtered-image address for this window's result
win_last  in  1  final window of the frame
im_rd_addr  out  16  image RAM read address (sync RAM, data returns next cycle)
im_rd_data  in  PIX_W  image RAM read data
k_rd_addr  out  16  kernel RAM read address (sync RAM, 1-cycle latency)
k_rd_data  in  COEF_W  kernel RAM read data
wr_en  out  1  filtered-image write strobe, one cycle per window
wr_addr  out  16  filtered-image write address
wr_data  out  PIX_W  filtered pixel
busy  out  1  high in any state other than IDLE
done  out  1  frame complete flag

Behaviour:
- Reset while rst is low, asynchronous:
  - state IDLE; row/col counters, accumulator and latched base/dst/last cleared.
  - wr_en=0, wr_addr=0, wr_data=0, done=0, busy=0, win_ready=1.
  - Reset mid-window aborts it; no write is issued.
- FSM states: IDLE, FETCH, DRAIN, WRITE.
- IDLE:
  - Handshake when win_valid && win_ready.
  - Latches win_base/win_dst/win_last, clears acc, r=c=0, clears done, goes to FETCH.
- FETCH, exactly KER_SIZE² cycles:
  - im_rd_addr = base + r*IMG_SIZE + c, modulo 2^16.
  - k_rd_addr = r*KER_SIZE + c.
  - c increments; at c=KER_SIZE-1, c wraps to 0 and r increments.
  - After issuing tap KER_SIZE²-1, go to DRAIN.
  - Outside FETCH both read addresses drive 0.
- Accumulate, the cycle after each issue (FETCH cycles 2..K² and DRAIN):
  - acc += zero-extended im_rd_data × sign-extended k_rd_data.
  - Product is PIX_W+COEF_W+1 bits, sign-extended to ACC_W.
  - Accumulator wraps two's-complement; no saturation.
- DRAIN: one cycle, absorbs the final product, then WRITE.
- WRITE: one cycle.
  - wr_en=1, wr_addr=dst.
  - wr_data = clip(acc >>> SHIFT) to [0, 2^PIX_W-1].
  - If the latched last is set, done goes high on this edge. done stays high until the next handshake.
  - Return to IDLE.
- Timing for K=3, handshake edge = cycle 0:
  - FETCH cycles 1..9, DRAIN cycle 10, WRITE (wr_en) cycle 11.
  - win_ready high again cycle 12.
  - Throughput is one window per K²+3 cycles.
- win_valid while busy is ignored. The requester holds it; there is no queuing.
- No bounds checking of win_base. Caller guarantees the window lies inside the image.

Optional Feature:
- Macro CONV_ABS_EN.
- Defined: the WRITE value is |acc >>> SHIFT| clipped to 2^PIX_W-1, giving edge-magnitude output.
- Undefined: negative results clip to 0.
- The macro does not change cycle timing.

Test Plan:
- Reset: assert rst low during FETCH cycle 5 -> all outputs 0 immediately. After release: win_ready=1, busy=0, and no wr_en for the aborted window.
- Address sequence: win_base=23, K=3 -> im_rd_addr 23,24,25,33,34,35,43,44,45 on cycles 1..9; k_rd_addr 0..8; both 0 on cycle 10.
- Identity kernel (tap 4 = 1, others 0), image[i]=i, win_base=0, win_dst=7 -> wr_en only on cycle 11, wr_addr=7, wr_data=11; win_ready returns cycle 12.
- Clipping: all coefs 1, all pixels 200 -> acc 1800, wr_data=255 with SHIFT=0. With SHIFT=3, wr_data=225.
- Negative sum: all coefs -1 (0xFF), pixels 10 -> acc -90. wr_data=0 without CONV_ABS_EN; wr_data=90 with CONV_ABS_EN.
- Frame run, IMG_SIZE=10: driver issues 64 windows back-to-back, last flagged on the final one, win_valid held high while busy.
  - Exactly 64 wr_en pulses, each 12 cycles apart.
  - No double acceptance.
  - done rises the cycle after the 64th wr_en and clears on the next accepted window.
